// File: rtl/cr_tlvb.sv
`default_nettype none
// ============================================================================
// Module   : cr_tlvb
// Purpose  : TLV builder. Accepts a TLV header request (type + payload length)
//            and a stream of 64-bit payload words, frames them as AXI4-stream
//            words (header word with SoT, payload words, EoT/tlast on the last
//            word), and buffers the result in a show-ahead output FIFO that is
//            drained with the rd/empty/aempty pull handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   module_id[4:0]           inserted into header word bits [12:8]
//   hdr_wr/hdr_typ/hdr_len   header request; hdr_ready = may accept
//   pl_wr/pl_data            payload word; pl_ready = may accept
//   ob_rd                    pop FIFO head
//   ob_empty/ob_aempty       FIFO status
//   ob_tdata/tuser/tstrb/tlast  head word (zero while empty)
//   tlvb_error               sticky protocol-violation flag
// ============================================================================
module cr_tlvb #(
  parameter int N_OF_ENTRIES    = 16,
  parameter int N_OF_AFULL_VAL  = 4,
  parameter int N_OF_AEMPTY_VAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  module_id,
  input  logic        hdr_wr,
  input  logic [7:0]  hdr_typ,
  input  logic [9:0]  hdr_len,
  output logic        hdr_ready,
  input  logic        pl_wr,
  input  logic [63:0] pl_data,
  output logic        pl_ready,
  input  logic        ob_rd,
  output logic        ob_empty,
  output logic        ob_aempty,
  output logic [63:0] ob_tdata,
  output logic [7:0]  ob_tuser,
  output logic [7:0]  ob_tstrb,
  output logic        ob_tlast,
  output logic        tlvb_error
);

  localparam int AW = $clog2(N_OF_ENTRIES);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_FULL     = CW'(N_OF_ENTRIES);
  localparam logic [CW-1:0] C_AFULL_TH = CW'(N_OF_ENTRIES - N_OF_AFULL_VAL);
  localparam logic [CW-1:0] C_AEMPTY   = CW'(N_OF_AEMPTY_VAL);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // FIFO entry layout: {EoT, SoT, data[63:0]}
  logic [65:0]   r_mem [N_OF_ENTRIES];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [9:0]    r_rem;
  logic [9:0]    w_rem_nxt;
  logic          r_err;

  logic          w_full;
  logic          w_afull;
  logic          w_empty;
  logic          w_hdr_acc;
  logic          w_pl_acc;
  logic          w_rd_acc;
  logic          w_wr_en;
  logic [65:0]   w_wdata;
  logic [10:0]   w_total_len;
  logic [63:0]   w_hdr_word;
  logic          w_violation;
  logic [65:0]   w_head;

  // --------------------------------------------------------------------------
  // Occupancy-derived status
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == C_FULL);
  assign w_afull = (r_count >= C_AFULL_TH);
  assign w_empty = (r_count == '0);

  // Readies depend only on registered state and occupancy (never on ob_rd),
  // so a pop in the same cycle cannot open up a full FIFO for a write.
  // rst is folded in so both readies are low for the whole reset assertion.
  assign hdr_ready = !rst && (r_state == ST_IDLE)    && !w_afull;
  assign pl_ready  = !rst && (r_state == ST_PAYLOAD) && !w_full;

  assign w_hdr_acc = hdr_wr && hdr_ready;
  assign w_pl_acc  = pl_wr  && pl_ready;
  assign w_rd_acc  = ob_rd  && !w_empty;

  assign w_violation = (hdr_wr && !hdr_ready) ||
                       (pl_wr  && !pl_ready)  ||
                       (ob_rd  && w_empty);

  // Header word: total word count includes the header itself.
  assign w_total_len = {1'b0, hdr_len} + 11'd1;
  assign w_hdr_word  = {37'd0, w_total_len, 3'd0, module_id, hdr_typ};

  // --------------------------------------------------------------------------
  // Framing FSM: next-state and FIFO write generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_wr_en     = 1'b0;
    w_wdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_acc) begin
          w_wr_en   = 1'b1;
          // A zero-length TLV is a single word carrying both SoT and EoT.
          w_wdata   = {(hdr_len == 10'd0), 1'b1, w_hdr_word};
          w_rem_nxt = hdr_len;
          if (hdr_len != 10'd0) begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_pl_acc) begin
          w_wr_en   = 1'b1;
          w_wdata   = {(r_rem == 10'd1), 1'b0, pl_data};
          w_rem_nxt = r_rem - 10'd1;
          if (r_rem == 10'd1) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_violation) begin
      r_err <= 1'b1;
    end
  end

  assign tlvb_error = r_err;

  // --------------------------------------------------------------------------
  // Output FIFO: pointers wrap naturally because depth is a power of two.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible when count > 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead head outputs, forced to zero while empty
  // --------------------------------------------------------------------------
  assign w_head    = r_mem[r_rd_ptr];
  assign ob_empty  = w_empty;
  assign ob_aempty = (r_count <= C_AEMPTY);
  assign ob_tdata  = w_empty ? 64'd0 : w_head[63:0];
  assign ob_tuser  = w_empty ? 8'd0  : {6'd0, w_head[65], w_head[64]};
  assign ob_tstrb  = w_empty ? 8'd0  : 8'hFF;
  assign ob_tlast  = w_empty ? 1'b0  : w_head[65];

endmodule
`default_nettype wire

// File: tb/tb_cr_tlvb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_tlvb
// Purpose  : Self-checking bench for cr_tlvb. Expected words are queued when
//            stimulus is accepted and compared when they reach the FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_tlvb;

  localparam int N  = 16;
  localparam int AF = 4;
  localparam int AE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  module_id = 5'd3;
  logic        hdr_wr = 1'b0;
  logic [7:0]  hdr_typ = '0;
  logic [9:0]  hdr_len = '0;
  logic        hdr_ready;
  logic        pl_wr = 1'b0;
  logic [63:0] pl_data = '0;
  logic        pl_ready;
  logic        ob_rd = 1'b0;
  logic        ob_empty;
  logic        ob_aempty;
  logic [63:0] ob_tdata;
  logic [7:0]  ob_tuser;
  logic [7:0]  ob_tstrb;
  logic        ob_tlast;
  logic        tlvb_error;

  cr_tlvb #(
    .N_OF_ENTRIES   (N),
    .N_OF_AFULL_VAL (AF),
    .N_OF_AEMPTY_VAL(AE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .module_id (module_id),
    .hdr_wr    (hdr_wr),
    .hdr_typ   (hdr_typ),
    .hdr_len   (hdr_len),
    .hdr_ready (hdr_ready),
    .pl_wr     (pl_wr),
    .pl_data   (pl_data),
    .pl_ready  (pl_ready),
    .ob_rd     (ob_rd),
    .ob_empty  (ob_empty),
    .ob_aempty (ob_aempty),
    .ob_tdata  (ob_tdata),
    .ob_tuser  (ob_tuser),
    .ob_tstrb  (ob_tstrb),
    .ob_tlast  (ob_tlast),
    .tlvb_error(tlvb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  u;
  } exp_t;

  typedef struct {
    logic [7:0]  typ;
    logic [9:0]  len;
    logic [63:0] hdr;
  } vec_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model of the builder's externally visible state
  int   m_cnt  = 0;
  bit   m_inpl = 1'b0;
  int   m_rem  = 0;
  bit   m_err  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] hdr_word(input logic [7:0] typ, input logic [9:0] len);
    logic [10:0] tot;
    tot = 11'(len) + 11'd1;
    return {37'd0, tot, 3'd0, 5'd3, typ};
  endfunction

  // One clock cycle: check status, drive inputs, check/pop head, update model.
  task automatic step(input logic hw, input logic [7:0] typ, input logic [9:0] len,
                      input logic [63:0] exp_hdr, input logic pw, input logic [63:0] pd,
                      input logic rd);
    bit   exp_hr, exp_pr, eot, wr, pop;
    exp_t e;
    @(negedge clk);
    chk("tlvb_error", 64'(tlvb_error), 64'(m_err));
    chk("ob_empty",   64'(ob_empty),   64'(m_cnt == 0));
    chk("ob_aempty",  64'(ob_aempty),  64'(m_cnt <= AE));
    exp_hr = !m_inpl && (m_cnt <= N - AF - 1);
    exp_pr = m_inpl && (m_cnt < N);
    hdr_wr = hw; hdr_typ = typ; hdr_len = len;
    pl_wr = pw; pl_data = pd; ob_rd = rd;
    chk("hdr_ready", 64'(hdr_ready), 64'(exp_hr));
    chk("pl_ready",  64'(pl_ready),  64'(exp_pr));
    pop = rd && (m_cnt > 0);
    if (pop) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("ob_tdata", ob_tdata, e.d);
        chk("ob_tuser", 64'(ob_tuser), 64'(e.u));
        chk("ob_tlast", 64'(ob_tlast), 64'(e.u[1]));
        chk("ob_tstrb", 64'(ob_tstrb), 64'h00FF);
      end
    end
    if ((rd && m_cnt == 0) || (hw && !exp_hr) || (pw && !exp_pr)) m_err = 1'b1;
    wr = 1'b0;
    if (hw && exp_hr) begin
      wr = 1'b1;
      e.d = exp_hdr;
      e.u = (len == 10'd0) ? 8'h03 : 8'h01;
      q.push_back(e);
      if (len != 10'd0) begin
        m_inpl = 1'b1;
        m_rem  = int'(len);
      end
    end
    if (pw && exp_pr) begin
      wr  = 1'b1;
      eot = (m_rem == 1);
      e.d = pd;
      e.u = eot ? 8'h02 : 8'h00;
      q.push_back(e);
      m_rem--;
      if (eot) m_inpl = 1'b0;
    end
    m_cnt = m_cnt + int'(wr) - int'(pop);
    @(posedge clk);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b0, 64'd0, rd);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * N && m_cnt > 0; k++) idle(1'b1);
    chk("drained", 64'(m_cnt), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    hdr_wr = 1'b0; pl_wr = 1'b0; ob_rd = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ob_empty",  64'(ob_empty),   64'd1);
    chk("rst_ob_aempty", 64'(ob_aempty),  64'd1);
    chk("rst_ob_tdata",  ob_tdata,        64'd0);
    chk("rst_ob_tuser",  64'(ob_tuser),   64'd0);
    chk("rst_ob_tstrb",  64'(ob_tstrb),   64'd0);
    chk("rst_ob_tlast",  64'(ob_tlast),   64'd0);
    chk("rst_hdr_ready", 64'(hdr_ready),  64'd0);
    chk("rst_pl_ready",  64'(pl_ready),   64'd0);
    chk("rst_error",     64'(tlvb_error), 64'd0);
    q.delete();
    m_cnt = 0; m_inpl = 1'b0; m_rem = 0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{typ: 8'h05, len: 10'd0,    hdr: 64'h0000_0000_0001_0305};
    vecs[1] = '{typ: 8'hAA, len: 10'd3,    hdr: 64'h0000_0000_0004_03AA};
    vecs[2] = '{typ: 8'h12, len: 10'd1,    hdr: 64'h0000_0000_0002_0312};
    vecs[3] = '{typ: 8'h80, len: 10'd7,    hdr: 64'h0000_0000_0008_0380};
    vecs[4] = '{typ: 8'hFF, len: 10'd1023, hdr: 64'h0000_0000_0400_03FF};

    do_reset();

    // Single zero-length TLV: one word, count 1, then empty after the pop.
    step(1'b1, vecs[0].typ, vecs[0].len, vecs[0].hdr, 1'b0, 64'd0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Table: TLVs back-to-back with the FIFO drained concurrently.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].typ, vecs[i].len, vecs[i].hdr, 1'b0, 64'd0, m_cnt != 0);
      for (int j = 0; j < int'(vecs[i].len); j++)
        step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, {$urandom, $urandom}, m_cnt != 0);
    end
    drain();

    // Full boundary with pointer wrap: hdr_len=20, no reads until full.
    step(1'b1, 8'h33, 10'd20, hdr_word(8'h33, 10'd20), 1'b0, 64'd0, 1'b0);
    for (int j = 0; j < 15; j++)
      step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0);
    chk("full_count", 64'(m_cnt), 64'd16);
    idle(1'b1);                                           // pl_ready low despite ob_rd
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0);
    idle(1'b0);                                           // full again
    for (int k = 0; k < 40 && m_inpl; k++)
      step(1'b0, 8'd0, 10'd0, 64'd0, m_cnt < N, {$urandom, $urandom}, m_cnt != 0);
    chk("full_tlv_done", 64'(m_inpl), 64'd0);
    drain();

    // Header throttle at count=12: rejected header, error set, FIFO unchanged.
    step(1'b1, 8'h44, 10'd11, hdr_word(8'h44, 10'd11), 1'b0, 64'd0, 1'b0);
    for (int j = 0; j < 11; j++)
      step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, {$urandom, $urandom}, 1'b0);
    chk("afull_count", 64'(m_cnt), 64'd12);
    step(1'b1, 8'h55, 10'd2, hdr_word(8'h55, 10'd2), 1'b0, 64'd0, 1'b0);
    idle(1'b0);
    drain();
    idle(1'b0);

    // ob_rd while empty.
    do_reset();
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // pl_wr in IDLE; error must hold through a following valid TLV.
    do_reset();
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    idle(1'b0);
    step(1'b1, 8'h07, 10'd0, hdr_word(8'h07, 10'd0), 1'b0, 64'd0, 1'b0);
    drain();
    idle(1'b0);

    // Reset in the middle of a 5-word TLV, then a clean hdr_len=1 TLV.
    do_reset();
    step(1'b1, 8'h66, 10'd5, hdr_word(8'h66, 10'd5), 1'b0, 64'd0, 1'b0);
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, 64'h1111_1111_1111_1111, 1'b0);
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, 64'h2222_2222_2222_2222, 1'b0);
    do_reset();
    step(1'b1, 8'h77, 10'd1, hdr_word(8'h77, 10'd1), 1'b0, 64'd0, 1'b0);
    step(1'b0, 8'd0, 10'd0, 64'd0, 1'b1, 64'h3333_3333_3333_3333, 1'b1);
    drain();
    idle(1'b0);

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cr_tlvb.md
# cr_tlvb

TLV builder: the transmit-side counterpart of the TLV parser. It accepts a TLV header request (type plus payload length) and a stream of 64-bit payload words from a user engine. It serializes them into framed AXI4-stream data-path words (header word with SoT, payload words, EoT/tlast on the final word) and buffers them in an output FIFO. The FIFO is drained by the downstream stage using the same rd/empty/aempty pull handshake as the rest of the TLV path.

## Interface
Parameters:
- N_OF_ENTRIES, 16, output FIFO depth in words (power of 2, ≥4)
- N_OF_AFULL_VAL, 4, afull asserted when free entries ≤ this value
- N_OF_AEMPTY_VAL, 1, ob_aempty asserted when occupancy ≤ this value

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- module_id  in  5  inserted into header word; static after reset
- hdr_wr  in  1  header request strobe
- hdr_typ  in  8  TLV type
- hdr_len  in  10  payload length in 64-bit words, 0..1023
- hdr_ready  out  1  header may be accepted this cycle
- pl_wr  in  1  payload word strobe
- pl_data  in  64  payload word
- pl_ready  out  1  payload word may be accepted this cycle
- ob_rd  in  1  pop output FIFO head
- ob_empty  out  1  output FIFO empty
- ob_aempty  out  1  output FIFO almost empty
- ob_tdata  out  64  head word data
- ob_tuser  out  8  bit0 SoT, bit1 EoT, others 0
- ob_tstrb  out  8  always 8'hFF for valid words
- ob_tlast  out  1  last word of TLV (equals EoT)
- tlvb_error  out  1  sticky protocol-violation flag

## Operation
- Header word format: [7:0]=hdr_typ, [12:8]=module_id, [15:13]=0, [26:16]=hdr_len+1 (11-bit total words incl. header), [63:27]=0. The header carries SoT=1.
- FSM states:
  - IDLE: hdr_ready = !of_afull; pl_ready=0. On hdr_wr&&hdr_ready, the header word is written to the FIFO on that edge and rem<=hdr_len.
    - hdr_len==0: header also carries EoT=1/tlast=1; stay IDLE.
    - else: go to PAYLOAD.
  - PAYLOAD: hdr_ready=0; pl_ready = !of_full. On pl_wr&&pl_ready, pl_data is written and rem decrements. When rem==1, the word carries EoT/tlast and the FSM goes to IDLE.
- Payload words carry SoT=0. EoT=0 except the final word.
- Violations set tlvb_error (held until rst); the offending input is dropped with no FIFO write and no state change:
  - hdr_wr while !hdr_ready
  - pl_wr while !pl_ready
  - ob_rd while ob_empty
- FIFO: show-ahead; ob_* reflect the head word whenever ob_empty=0. Occupancy counter is 0..N_OF_ENTRIES (width clog2(N)+1).
  - of_full = count==N
  - of_afull = count ≥ N−N_OF_AFULL_VAL
  - ob_aempty = count ≤ N_OF_AEMPTY_VAL
- Pointers wrap modulo N_OF_ENTRIES.
- Simultaneous write and pop in the same cycle: count unchanged, both take effect.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - state=IDLE, count=0, pointers=0, tlvb_error=0
  - ob_empty=1, ob_aempty=1, ob_tdata/ob_tuser/ob_tstrb/ob_tlast=0
  - hdr_ready=0, pl_ready=0 while rst=1; hdr_ready=1 on the first cycle after deassertion
- Reset mid-TLV discards the partial TLV and all FIFO contents. No EoT is emitted for the discarded TLV.
- Latency: a word written at edge k is visible at the FIFO output (ob_empty=0) from cycle k+1. A pop at edge k presents the next word in cycle k+1.
- hdr_ready and pl_ready are combinational from registered state and count; no combinational path from ob_rd.
- Full boundary: pl_ready=0 while count==N, even if ob_rd is asserted that cycle.
- Header throttle: a header is accepted only when at least N_OF_AFULL_VAL+1 entries are free.
- Throughput: 1 word/cycle sustained when ob_rd is held high. A header may be accepted in the cycle after a final payload word (no dead cycle beyond the FSM return to IDLE).

## Test plan
- Reset, then hdr_typ=8'h05, hdr_len=0, module_id=3 -> one word: tdata=64'h0000_0000_0001_0305, tuser=2'b11, tlast=1. FIFO count=1, then empty after ob_rd.
- hdr_len=3, payload A,B,C back-to-back -> 4 words. Header tdata[26:16]=4 with SoT. C carries EoT/tlast. Next-cycle hdr_ready=1.
- ob_rd=0, stream hdr_len=20 -> pl_ready drops at count=16 and ob_empty=0. Drain one word -> exactly one more word accepted. No loss; order preserved across pointer wrap.
- With count=12 (afull at N=16, AFULL=4), hdr_wr -> hdr_ready=0, tlvb_error=1, FIFO unchanged.
- ob_rd while empty and pl_wr in IDLE -> tlvb_error=1, counts and state unchanged, error holds until rst.
- rst pulsed after 2 of 5 payload words -> all outputs at reset values. A following hdr_len=1 TLV is emitted cleanly with SoT on its header.
